// File: rtl/m_csr_pkg.sv
// Shared constants for the machine-mode CSR file: addresses, field positions,
// write masks and the read/set/clear operand combiner.
package m_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

  // Interrupt cause codes double as the mie/mip bit positions.
  localparam int IRQ_CAUSE_MSI = 3;
  localparam int IRQ_CAUSE_MTI = 7;
  localparam int IRQ_CAUSE_MEI = 11;

  localparam logic [31:0] MSTATUS_MPP_FIXED = 32'h0000_1800;
  localparam logic [31:0] MIE_WMASK         = (32'h1 << IRQ_CAUSE_MSI) |
                                              (32'h1 << IRQ_CAUSE_MTI) |
                                              (32'h1 << IRQ_CAUSE_MEI);
  localparam logic [31:0] MEPC_WMASK        = 32'hFFFF_FFFC;
  localparam logic [31:0] MISA_VALUE        = 32'h4000_0100;
  localparam logic [31:0] MHARTID_VALUE     = 32'h0000_0000;

  typedef enum logic [1:0] {
    WSC_NONE  = 2'b00,
    WSC_WRITE = 2'b01,
    WSC_SET   = 2'b10,
    WSC_CLEAR = 2'b11
  } wsc_mode_e;

  function automatic logic [31:0] csr_apply_wsc(input logic [1:0] mode,
                                                input logic [31:0] old_val,
                                                input logic [31:0] operand);
    logic [31:0] result;
    case (wsc_mode_e'(mode))
      WSC_WRITE: result = operand;
      WSC_SET:   result = old_val | operand;
      WSC_CLEAR: result = old_val & ~operand;
      default:   result = old_val;
    endcase
    return result;
  endfunction

  function automatic logic csr_is_writable(input logic [11:0] addr);
    logic ok;
    case (addr)
      CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
      CSR_MTVAL, CSR_MIP, CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET,
      CSR_MINSTRETH: ok = 1'b1;
      default:       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/m_csr_counter64.sv
// 64-bit free-running counter with independent 32-bit half writes; a half
// write replaces that half of the incremented value for the cycle.
module m_csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] count_o
);

  logic [63:0] count_q;
  logic [63:0] count_d;

  // The high half still picks up the carry out of the old low half when only
  // the low half is written.
  always_comb begin
    count_d = count_q + {63'b0, inc_i};
    if (wr_lo_i) count_d[31:0]  = wdata_i;
    if (wr_hi_i) count_d[63:32] = wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/m_csr_file.sv
// Machine-mode CSR file for the RV32I core: CSR access port, trap entry and
// MRET state updates, redirect targets and interrupt-pending indication.
module m_csr_file
  import m_csr_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] raddr_i,
  output logic [31:0] rdata_o,
  input  logic        csr_w_i,
  input  logic [11:0] waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  csr_wsc_mode_i,
  output logic        csr_illegal_o,
  input  logic        trap_valid_i,
  input  logic [31:0] trap_cause_i,
  input  logic [31:0] trap_epc_i,
  input  logic [31:0] trap_tval_i,
  input  logic        mret_valid_i,
  input  logic        instret_inc_i,
  input  logic        ext_irq_i,
  input  logic        timer_irq_i,
  output logic        irq_pending_o,
  output logic [31:0] trap_target_o,
  output logic [31:0] mret_target_o,
  output logic [31:0] mstatus_out_o
);

  logic        mie_bit_q, mie_bit_d;
  logic        mpie_bit_q, mpie_bit_d;
  logic        msip_q, msip_d;
  logic [31:0] mie_q, mie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;

  logic [63:0] mcycle_cnt;
  logic [63:0] minstret_cnt;
  logic [31:0] mstatus_val;
  logic [31:0] mip_val;
  logic [31:0] old_val;
  logic [31:0] new_val;
  logic [31:0] tvec_base;
  logic        wr_en;

  assign mstatus_val = MSTATUS_MPP_FIXED |
                       ({31'b0, mpie_bit_q} << MSTATUS_MPIE_BIT) |
                       ({31'b0, mie_bit_q}  << MSTATUS_MIE_BIT);

  assign mip_val = ({31'b0, msip_q}      << IRQ_CAUSE_MSI) |
                   ({31'b0, timer_irq_i} << IRQ_CAUSE_MTI) |
                   ({31'b0, ext_irq_i}   << IRQ_CAUSE_MEI);

  function automatic logic [31:0] read_csr(input logic [11:0] addr);
    logic [31:0] val;
    case (addr)
      CSR_MSTATUS:   val = mstatus_val;
      CSR_MISA:      val = MISA_VALUE;
      CSR_MIE:       val = mie_q;
      CSR_MTVEC:     val = mtvec_q;
      CSR_MSCRATCH:  val = mscratch_q;
      CSR_MEPC:      val = mepc_q;
      CSR_MCAUSE:    val = mcause_q;
      CSR_MTVAL:     val = mtval_q;
      CSR_MIP:       val = mip_val;
      CSR_MCYCLE:    val = mcycle_cnt[31:0];
      CSR_MCYCLEH:   val = mcycle_cnt[63:32];
      CSR_MINSTRET:  val = minstret_cnt[31:0];
      CSR_MINSTRETH: val = minstret_cnt[63:32];
      CSR_MHARTID:   val = MHARTID_VALUE;
      default:       val = 32'h0;
    endcase
    return val;
  endfunction

  assign rdata_o       = read_csr(raddr_i);
  assign csr_illegal_o = csr_w_i & ~csr_is_writable(waddr_i);

  // A committing trap squashes any CSR write issued alongside it.
  assign wr_en   = csr_w_i & (csr_wsc_mode_i != WSC_NONE) &
                   csr_is_writable(waddr_i) & ~trap_valid_i;
  assign old_val = read_csr(waddr_i);
  assign new_val = csr_apply_wsc(csr_wsc_mode_i, old_val, wdata_i);

  always_comb begin
    mie_bit_d  = mie_bit_q;
    mpie_bit_d = mpie_bit_q;
    msip_d     = msip_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;

    if (wr_en) begin
      case (waddr_i)
        CSR_MSTATUS: begin
          mie_bit_d  = new_val[MSTATUS_MIE_BIT];
          mpie_bit_d = new_val[MSTATUS_MPIE_BIT];
        end
        CSR_MIE:      mie_d      = new_val & MIE_WMASK;
        CSR_MTVEC:    mtvec_d    = new_val[1] ? {new_val[31:2], 2'b00} : new_val;
        CSR_MSCRATCH: mscratch_d = new_val;
        CSR_MEPC:     mepc_d     = new_val & MEPC_WMASK;
        CSR_MCAUSE:   mcause_d   = new_val;
        CSR_MTVAL:    mtval_d    = new_val;
        CSR_MIP:      msip_d     = new_val[IRQ_CAUSE_MSI];
        default:      ;
      endcase
    end

    // Trap entry outranks MRET; MRET overrides only the interrupt-enable stack.
    if (trap_valid_i) begin
      mepc_d     = trap_epc_i & MEPC_WMASK;
      mcause_d   = trap_cause_i;
      mtval_d    = trap_tval_i;
      mpie_bit_d = mie_bit_q;
      mie_bit_d  = 1'b0;
    end else if (mret_valid_i) begin
      mie_bit_d  = mpie_bit_q;
      mpie_bit_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mie_bit_q  <= 1'b0;
      mpie_bit_q <= 1'b0;
      msip_q     <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else begin
      mie_bit_q  <= mie_bit_d;
      mpie_bit_q <= mpie_bit_d;
      msip_q     <= msip_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
    end
  end

  m_csr_counter64 u_mcycle (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (1'b1),
    .wr_lo_i (wr_en && (waddr_i == CSR_MCYCLE)),
    .wr_hi_i (wr_en && (waddr_i == CSR_MCYCLEH)),
    .wdata_i (new_val),
    .count_o (mcycle_cnt)
  );

  m_csr_counter64 u_minstret (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (instret_inc_i),
    .wr_lo_i (wr_en && (waddr_i == CSR_MINSTRET)),
    .wr_hi_i (wr_en && (waddr_i == CSR_MINSTRETH)),
    .wdata_i (new_val),
    .count_o (minstret_cnt)
  );

  // Vectored mode offsets only interrupts; exceptions always go to the base.
  assign tvec_base = {mtvec_q[31:2], 2'b00};

  always_comb begin
    trap_target_o = tvec_base;
    if ((mtvec_q[1:0] == 2'b01) && trap_cause_i[31])
      trap_target_o = tvec_base + {25'b0, trap_cause_i[4:0], 2'b00};
  end

  assign irq_pending_o = mie_bit_q & (|(mie_q & mip_val));
  assign mret_target_o = mepc_q;
  assign mstatus_out_o = mstatus_val;

endmodule

// File: tb/tb_m_csr_file.sv
// Self-checking bench for m_csr_file: directed scenarios with literal
// expectations, then randomized traffic compared against a behavioural model.
module tb_m_csr_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] raddr, waddr;
  logic [31:0] rdata, wdata;
  logic        csrW, csrIllegal;
  logic [1:0]  wscMode;
  logic        trapValid, mretValid, instretInc, extIrq, timerIrq;
  logic [31:0] trapCause, trapEpc, trapTval;
  logic        irqPending;
  logic [31:0] trapTarget, mretTarget, mstatusOut;

  int assertCount = 0;
  int failCount   = 0;
  bit checkEn     = 1'b0;

  // Behavioural model state, one variable per architectural register.
  bit          mMIE, mMPIE, mMSIP;
  logic [31:0] mIeReg, mTvec, mScratch, mEpc, mCause, mTval;
  logic [63:0] mCycle, mInstret;

  logic [11:0] addrTable [18] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340,
                                  12'h341, 12'h342, 12'h343, 12'h344, 12'hB00,
                                  12'hB80, 12'hB02, 12'hB82, 12'hF14, 12'h000,
                                  12'h345, 12'h7FF, 12'hB01};

  always #5 clk = ~clk;

  m_csr_file dut (
    .clk            (clk),
    .rst            (rst),
    .raddr_i        (raddr),
    .rdata_o        (rdata),
    .csr_w_i        (csrW),
    .waddr_i        (waddr),
    .wdata_i        (wdata),
    .csr_wsc_mode_i (wscMode),
    .csr_illegal_o  (csrIllegal),
    .trap_valid_i   (trapValid),
    .trap_cause_i   (trapCause),
    .trap_epc_i     (trapEpc),
    .trap_tval_i    (trapTval),
    .mret_valid_i   (mretValid),
    .instret_inc_i  (instretInc),
    .ext_irq_i      (extIrq),
    .timer_irq_i    (timerIrq),
    .irq_pending_o  (irqPending),
    .trap_target_o  (trapTarget),
    .mret_target_o  (mretTarget),
    .mstatus_out_o  (mstatusOut)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] modelRead(input logic [11:0] addr);
    case (addr)
      12'h300: return 32'h1800 | (mMPIE ? 32'h80 : 32'h0) | (mMIE ? 32'h8 : 32'h0);
      12'h301: return 32'h4000_0100;
      12'h304: return mIeReg;
      12'h305: return mTvec;
      12'h340: return mScratch;
      12'h341: return mEpc;
      12'h342: return mCause;
      12'h343: return mTval;
      12'h344: return (mMSIP ? 32'h8 : 32'h0) | (timerIrq ? 32'h80 : 32'h0) |
                      (extIrq ? 32'h800 : 32'h0);
      12'hB00: return mCycle[31:0];
      12'hB80: return mCycle[63:32];
      12'hB02: return mInstret[31:0];
      12'hB82: return mInstret[63:32];
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit modelWritable(input logic [11:0] addr);
    return (addr == 12'h300) || (addr == 12'h304) || (addr == 12'h305) ||
           (addr >= 12'h340 && addr <= 12'h344) || (addr == 12'hB00) ||
           (addr == 12'hB80) || (addr == 12'hB02) || (addr == 12'hB82);
  endfunction

  function automatic logic [31:0] modelTrapTarget();
    logic [31:0] base;
    base = mTvec & 32'hFFFF_FFFC;
    if (mTvec[1:0] == 2'b01 && trapCause[31]) return base + 32'(trapCause[4:0]) * 4;
    return base;
  endfunction

  task automatic modelStep();
    logic [31:0] oldV, nv;
    logic [63:0] cyc, ins;
    bit oldMie, oldMpie;
    if (rst) begin
      mMIE = 0; mMPIE = 0; mMSIP = 0;
      mIeReg = 0; mTvec = 0; mScratch = 0; mEpc = 0; mCause = 0; mTval = 0;
      mCycle = 0; mInstret = 0;
      return;
    end
    oldMie  = mMIE;
    oldMpie = mMPIE;
    cyc = mCycle + 64'd1;
    ins = mInstret + (instretInc ? 64'd1 : 64'd0);
    if (csrW && wscMode != 2'b00 && modelWritable(waddr) && !trapValid) begin
      oldV = modelRead(waddr);
      case (wscMode)
        2'b01:   nv = wdata;
        2'b10:   nv = oldV | wdata;
        default: nv = oldV & ~wdata;
      endcase
      case (waddr)
        12'h300: begin mMIE = nv[3]; mMPIE = nv[7]; end
        12'h304: mIeReg = nv & 32'h888;
        12'h305: mTvec = nv[1] ? (nv & 32'hFFFF_FFFC) : nv;
        12'h340: mScratch = nv;
        12'h341: mEpc = nv & 32'hFFFF_FFFC;
        12'h342: mCause = nv;
        12'h343: mTval = nv;
        12'h344: mMSIP = nv[3];
        12'hB00: cyc[31:0] = nv;
        12'hB80: cyc[63:32] = nv;
        12'hB02: ins[31:0] = nv;
        12'hB82: ins[63:32] = nv;
        default: ;
      endcase
    end
    if (trapValid) begin
      mEpc = trapEpc & 32'hFFFF_FFFC;
      mCause = trapCause;
      mTval = trapTval;
      mMPIE = oldMie;
      mMIE = 0;
    end else if (mretValid) begin
      mMIE = oldMpie;
      mMPIE = 1;
    end
    mCycle = cyc;
    mInstret = ins;
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("rdata", rdata, modelRead(raddr));
      checkOutput("csr_illegal", {31'b0, csrIllegal}, {31'b0, csrW && !modelWritable(waddr)});
      checkOutput("irq_pending", {31'b0, irqPending},
                  {31'b0, mMIE && ((mIeReg & modelRead(12'h344)) != 0)});
      checkOutput("trap_target", trapTarget, modelTrapTarget());
      checkOutput("mret_target", mretTarget, mEpc);
      checkOutput("mstatus_out", mstatusOut, modelRead(12'h300));
    end
  end

  task automatic tick();
    @(posedge clk);
    modelStep();
    #2;
  endtask

  task automatic applyStimulus(input logic [11:0] ra, input logic w,
                               input logic [11:0] wa, input logic [31:0] wd,
                               input logic [1:0] md);
    raddr = ra; csrW = w; waddr = wa; wdata = wd; wscMode = md;
    trapValid = 0; trapCause = 0; trapEpc = 0; trapTval = 0;
    mretValid = 0; instretInc = 0;
  endtask

  task automatic readCheck(input logic [11:0] addr, input logic [31:0] exp,
                           input string name);
    applyStimulus(addr, 0, 12'h0, 32'h0, 2'b00);
    @(negedge clk);
    #1;
    checkOutput(name, rdata, exp);
    tick();
  endtask

  task automatic writeOp(input logic [11:0] addr, input logic [31:0] data,
                         input logic [1:0] md);
    applyStimulus(addr, 1, addr, data, md);
    tick();
  endtask

  initial begin
    rst = 1; extIrq = 0; timerIrq = 0;
    applyStimulus(12'h0, 0, 12'h0, 32'h0, 2'b00);
    repeat (3) tick();
    rst = 0;
    checkEn = 1;

    readCheck(12'h300, 32'h0000_1800, "reset_mstatus");
    readCheck(12'hF14, 32'h0, "reset_mhartid");
    readCheck(12'h301, 32'h4000_0100, "reset_misa");

    writeOp(12'h300, 32'hFFFF_FFFF, 2'b01);
    readCheck(12'h300, 32'h0000_1888, "mstatus_write");
    writeOp(12'h300, 32'h8, 2'b11);
    readCheck(12'h300, 32'h0000_1880, "mstatus_clear");

    applyStimulus(12'h301, 1, 12'h301, 32'h0, 2'b01);
    @(negedge clk); #1;
    checkOutput("misa_illegal", {31'b0, csrIllegal}, 32'h1);
    tick();
    readCheck(12'h301, 32'h4000_0100, "misa_unchanged");

    writeOp(12'h300, 32'h8, 2'b10);
    writeOp(12'h304, 32'h800, 2'b01);
    applyStimulus(12'h344, 0, 12'h0, 32'h0, 2'b00);
    extIrq = 1;
    @(negedge clk); #1;
    checkOutput("ext_irq_pending", {31'b0, irqPending}, 32'h1);
    tick();

    writeOp(12'h305, 32'h201, 2'b01);
    applyStimulus(12'h340, 1, 12'h340, 32'hDEAD_BEEF, 2'b01);
    trapValid = 1; trapCause = 32'h8000_000B; trapEpc = 32'h100; trapTval = 32'h55;
    @(negedge clk); #1;
    checkOutput("vectored_target", trapTarget, 32'h0000_022C);
    tick();
    extIrq = 0;
    readCheck(12'h341, 32'h100, "trap_mepc");
    readCheck(12'h342, 32'h8000_000B, "trap_mcause");
    readCheck(12'h343, 32'h55, "trap_mtval");
    readCheck(12'h300, 32'h0000_1880, "trap_mstatus");
    readCheck(12'h340, 32'h0, "trap_drops_write");

    applyStimulus(12'h0, 0, 12'h0, 32'h0, 2'b00);
    mretValid = 1;
    tick();
    readCheck(12'h300, 32'h0000_1888, "mret_mstatus");
    applyStimulus(12'h0, 0, 12'h0, 32'h0, 2'b00);
    @(negedge clk); #1;
    checkOutput("mret_target", mretTarget, 32'h100);
    tick();

    writeOp(12'hB80, 32'h0, 2'b01);
    writeOp(12'hB00, 32'hFFFF_FFFF, 2'b01);
    readCheck(12'hB00, 32'hFFFF_FFFF, "mcycle_written");
    applyStimulus(12'hB80, 0, 12'h0, 32'h0, 2'b00);
    @(negedge clk); #1;
    checkOutput("mcycleh_carry", rdata, 32'h1);
    raddr = 12'hB00;
    #1;
    checkOutput("mcycle_wrap", rdata, 32'h0);
    tick();

    applyStimulus(12'hB02, 1, 12'hB02, 32'h5, 2'b01);
    instretInc = 1;
    tick();
    applyStimulus(12'hB02, 0, 12'h0, 32'h0, 2'b00);
    instretInc = 1;
    @(negedge clk); #1;
    checkOutput("minstret_write_wins", rdata, 32'h5);
    tick();
    readCheck(12'hB02, 32'h6, "minstret_inc");

    writeOp(12'h341, 32'h103, 2'b01);
    readCheck(12'h341, 32'h100, "mepc_align");
    writeOp(12'h305, 32'h3, 2'b01);
    readCheck(12'h305, 32'h0, "mtvec_mode_clamp");

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      applyStimulus(addrTable[$urandom_range(0, 17)], $urandom_range(0, 1) == 1,
                    addrTable[$urandom_range(0, 17)],
                    ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom,
                    2'($urandom_range(0, 3)));
      trapValid  = ($urandom_range(0, 11) == 0);
      trapCause  = $urandom;
      trapEpc    = $urandom;
      trapTval   = $urandom;
      mretValid  = ($urandom_range(0, 7) == 0);
      instretInc = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 7) == 0) extIrq = ~extIrq;
      if ($urandom_range(0, 7) == 0) timerIrq = ~timerIrq;
      tick();
    end

    @(negedge clk); #1;
    checkEn = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
